// File: rtl/z_bp_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states and their reset value.
package z_bp_pkg;

   typedef enum logic [1:0] {
      CntSnt = 2'b00,
      CntWnt = 2'b01,
      CntWt  = 2'b10,
      CntSt  = 2'b11
   } cnt_e;

   localparam cnt_e CntReset = CntWnt;

   // A counter predicts taken when its MSB is set.
   function automatic logic cnt_pred(input cnt_e c);
      return c[1];
   endfunction

endpackage

// File: rtl/z_sat_counter2.sv
// Next-state function of a 2-bit saturating counter: up on taken, down on not-taken.
module z_sat_counter2
   import z_bp_pkg::*;
(
   input  cnt_e count,
   input  logic taken,
   output cnt_e next_count
);

   always_comb begin
      next_count = count;
      unique case (count)
         CntSnt: next_count = taken ? CntWnt : CntSnt;
         CntWnt: next_count = taken ? CntWt  : CntSnt;
         CntWt:  next_count = taken ? CntSt  : CntWnt;
         CntSt:  next_count = taken ? CntSt  : CntWt;
         default: next_count = count;
      endcase
   end

endmodule

// File: rtl/z_branch_pred_ctrl.sv
// Bimodal branch predictor with an in-flight FIFO of {index, prediction} awaiting resolution.
// Define BP_GSHARE_EN to XOR a global outcome history into the lookup index.
module z_branch_pred_ctrl
   import z_bp_pkg::*;
#(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       lookup_valid,
   input  logic [31:0]                lookup_pc,
   output logic                       lookup_ready,
   output logic                       predict_taken,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   input  logic                       flush,
   output logic                       mispredict,
   output logic                       resolve_err,
   output logic [$clog2(DEPTH+1)-1:0] inflight_count
);

   localparam int unsigned Entries = 2 ** IDX_W;
   localparam int unsigned CntW    = $clog2(DEPTH + 1);
   localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
   localparam logic [PtrW-1:0] LastPtr   = PtrW'(DEPTH - 1);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             pred;
   } fifo_entry_t;

   cnt_e             cnt_q   [Entries];
   fifo_entry_t      fifo_q  [DEPTH];
   logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             mis_q, err_q;

   logic [IDX_W-1:0] pc_idx, lookup_idx;
   logic             push, pop, empty;
   fifo_entry_t      head;
   cnt_e             head_cnt, head_next;

   logic unused_pc;
   assign unused_pc = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

   assign pc_idx = lookup_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0] hist_q;
   logic [IDX_W:0]   hist_shift;

   assign hist_shift = {hist_q, resolve_taken};
   assign lookup_idx = pc_idx ^ hist_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
      end else if (pop) begin
         hist_q <= hist_shift[IDX_W-1:0];
      end
   end
`else
   assign lookup_idx = pc_idx;
`endif

   assign empty          = (count_q == '0);
   assign lookup_ready   = (count_q != FullCount);
   assign predict_taken  = cnt_pred(cnt_q[lookup_idx]);
   assign inflight_count = count_q;
   assign mispredict     = mis_q;
   assign resolve_err    = err_q;

   // Readiness uses start-of-cycle occupancy, so a same-cycle pop never frees a slot early.
   assign push = lookup_valid && lookup_ready && !flush;
   assign pop  = resolve_valid && !empty;

   assign head     = fifo_q[rd_ptr_q];
   assign head_cnt = cnt_q[head.idx];

   z_sat_counter2 u_sat (
      .count      (head_cnt),
      .taken      (resolve_taken),
      .next_count (head_next)
   );

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(Entries); i++) begin
            cnt_q[i] <= CntReset;
         end
      end else if (pop) begin
         cnt_q[head.idx] <= head_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push) begin
         fifo_q[wr_ptr_q] <= '{idx: lookup_idx, pred: predict_taken};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         mis_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         mis_q <= pop && (resolve_taken != head.pred);
         err_q <= resolve_valid && empty;
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
               count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
               count_q <= count_q - CntW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_z_branch_pred_ctrl.sv
// Self-checking bench: directed vector table, mid-run reset, then random traffic against a queue model.
module tb_z_branch_pred_ctrl;

   localparam int Depth = 4;
   localparam int IdxW  = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        lookup_valid, resolve_valid, resolve_taken, flush;
   logic [31:0] lookup_pc;
   logic        lookup_ready, predict_taken, mispredict, resolve_err;
   logic [2:0]  inflight_count;

   z_branch_pred_ctrl #(.IDX_W(IdxW), .DEPTH(Depth)) dut (
      .clock          (clock),
      .reset          (reset),
      .lookup_valid   (lookup_valid),
      .lookup_pc      (lookup_pc),
      .lookup_ready   (lookup_ready),
      .predict_taken  (predict_taken),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .flush          (flush),
      .mispredict     (mispredict),
      .resolve_err    (resolve_err),
      .inflight_count (inflight_count)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: counters as plain 0..3 integers, in-flight branches as a queue.
   typedef struct {
      int idx;
      bit pred;
   } ent_t;

   int   m_ctr[16];
   ent_t m_q[$];
   int   m_hist;
   bit   m_mis, m_err;

   function automatic int m_idx(input logic [31:0] pc);
      return ((int'(pc) >> 2) ^ m_hist) & 15;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_q.delete();
      m_hist = 0;
      m_mis  = 0;
      m_err  = 0;
   endtask

   task automatic m_step(input bit lv, input logic [31:0] pc, input bit rv, input bit rt,
                         input bit fl);
      bit   ready;
      int   li;
      bit   lp;
      ent_t e;
      ready = m_q.size() < Depth;
      li    = m_idx(pc);
      lp    = m_ctr[li] >= 2;
      m_mis = 0;
      m_err = 0;
      if (rv) begin
         if (m_q.size() > 0) begin
            e = m_q.pop_front();
            if (rt) m_ctr[e.idx] = (m_ctr[e.idx] == 3) ? 3 : m_ctr[e.idx] + 1;
            else    m_ctr[e.idx] = (m_ctr[e.idx] == 0) ? 0 : m_ctr[e.idx] - 1;
            m_mis = (rt != e.pred);
`ifdef BP_GSHARE_EN
            m_hist = ((m_hist << 1) | int'(rt)) & 15;
`endif
         end else begin
            m_err = 1;
         end
      end
      if (fl) m_q.delete();
      else if (lv && ready) m_q.push_back('{idx: li, pred: lp});
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".pred"},  32'(predict_taken),  32'(m_ctr[m_idx(lookup_pc)] >= 2));
      chk({tag, ".ready"}, 32'(lookup_ready),   32'(m_q.size() < Depth));
      chk({tag, ".count"}, 32'(inflight_count), 32'(m_q.size()));
      chk({tag, ".mis"},   32'(mispredict),     32'(m_mis));
      chk({tag, ".err"},   32'(resolve_err),    32'(m_err));
   endtask

   task automatic drive(input bit lv, input logic [31:0] pc, input bit rv, input bit rt,
                        input bit fl);
      lookup_valid  = lv;
      lookup_pc     = pc;
      resolve_valid = rv;
      resolve_taken = rt;
      flush         = fl;
   endtask

   typedef struct {
      bit          lv;
      logic [31:0] pc;
      bit          rv, rt, fl;
      bit          pred, rdy;
      int          cnt;
      bit          mis, err;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit lv, input logic [31:0] pc, input bit rv, input bit rt,
                      input bit fl, input bit pred, input bit rdy, input int cnt, input bit mis,
                      input bit err);
      tbl.push_back('{lv: lv, pc: pc, rv: rv, rt: rt, fl: fl, pred: pred, rdy: rdy, cnt: cnt,
                      mis: mis, err: err});
   endtask

   initial begin
      //   lv pc     rv rt fl  pred rdy cnt mis err
`ifdef BP_GSHARE_EN
      add(1, 32'h00, 0, 0, 0,  0,   1,  0,  0,  0);
      add(0, 32'h04, 1, 1, 0,  0,   1,  1,  0,  0);
      add(1, 32'h04, 0, 0, 0,  1,   1,  0,  1,  0);  // history 0b0001 folds 0x04 onto index 0
      add(0, 32'h04, 1, 0, 0,  1,   1,  1,  0,  0);
      add(0, 32'h08, 0, 0, 0,  0,   1,  0,  1,  0);
`else
      add(1, 32'h40, 0, 0, 0,  0,   1,  0,  0,  0);
      add(0, 32'h40, 1, 1, 0,  0,   1,  1,  0,  0);
      add(1, 32'h40, 0, 0, 0,  1,   1,  0,  1,  0);
      add(0, 32'h40, 1, 1, 0,  1,   1,  1,  0,  0);
      add(1, 32'h40, 0, 0, 0,  1,   1,  0,  0,  0);
      add(0, 32'h40, 1, 0, 0,  1,   1,  1,  0,  0);
      add(0, 32'h40, 0, 0, 0,  1,   1,  0,  1,  0);
      add(1, 32'h44, 0, 0, 0,  0,   1,  0,  0,  0);
      add(1, 32'h44, 0, 0, 0,  0,   1,  1,  0,  0);
      add(1, 32'h44, 0, 0, 0,  0,   1,  2,  0,  0);
      add(1, 32'h44, 0, 0, 0,  0,   1,  3,  0,  0);
      add(1, 32'h44, 0, 0, 0,  0,   0,  4,  0,  0);
      add(1, 32'h44, 1, 0, 0,  0,   0,  4,  0,  0);
      add(0, 32'h44, 0, 0, 0,  0,   1,  3,  0,  0);
      add(0, 32'h44, 1, 0, 0,  0,   1,  3,  0,  0);
      add(0, 32'h44, 1, 0, 0,  0,   1,  2,  0,  0);
      add(0, 32'h44, 1, 0, 0,  0,   1,  1,  0,  0);
      add(0, 32'h40, 1, 1, 0,  1,   1,  0,  0,  0);
      add(0, 32'h40, 0, 0, 0,  1,   1,  0,  0,  1);
      add(1, 32'h48, 0, 0, 0,  0,   1,  0,  0,  0);
      add(1, 32'h48, 0, 0, 0,  0,   1,  1,  0,  0);
      add(1, 32'h48, 0, 0, 0,  0,   1,  2,  0,  0);
      add(1, 32'h48, 1, 1, 1,  0,   1,  3,  0,  0);
      add(0, 32'h48, 0, 0, 0,  1,   1,  0,  1,  0);
      add(1, 32'h00, 0, 0, 0,  1,   1,  0,  0,  0);
      add(1, 32'h40, 1, 0, 0,  1,   1,  1,  0,  0);  // same-index lookup sees pre-update value
      add(0, 32'h40, 1, 1, 0,  0,   1,  1,  1,  0);
      add(0, 32'h40, 0, 0, 0,  1,   1,  0,  0,  0);
`endif

      reset = 1'b1;
      drive(0, 32'h0, 0, 0, 0);
      m_reset();
      repeat (2) @(negedge clock);
      reset = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clock);
         drive(tbl[i].lv, tbl[i].pc, tbl[i].rv, tbl[i].rt, tbl[i].fl);
         #1;
         chk($sformatf("tbl%0d.pred", i),  32'(predict_taken),  32'(tbl[i].pred));
         chk($sformatf("tbl%0d.ready", i), 32'(lookup_ready),   32'(tbl[i].rdy));
         chk($sformatf("tbl%0d.count", i), 32'(inflight_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d.mis", i),   32'(mispredict),     32'(tbl[i].mis));
         chk($sformatf("tbl%0d.err", i),   32'(resolve_err),    32'(tbl[i].err));
         check_model($sformatf("tblm%0d", i));
         m_step(tbl[i].lv, tbl[i].pc, tbl[i].rv, tbl[i].rt, tbl[i].fl);
      end

      // Reset mid-operation with a mispredict pulse pending.
      @(negedge clock);
      drive(1, 32'h48, 0, 0, 0);
      #1;
      check_model("mid0");
      m_step(1, 32'h48, 0, 0, 0);
      @(negedge clock);
      drive(1, 32'h40, 1, 0, 0);
      #1;
      check_model("mid1");
      m_step(1, 32'h40, 1, 0, 0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      drive(0, 32'h48, 1, 1, 0);
      #1;
      chk("rst.mis",   32'(mispredict),     32'd0);
      chk("rst.err",   32'(resolve_err),    32'd0);
      chk("rst.count", 32'(inflight_count), 32'd0);
      chk("rst.ready", 32'(lookup_ready),   32'd1);
      chk("rst.pred",  32'(predict_taken),  32'd0);
      m_reset();
      @(negedge clock);
      reset = 1'b0;
      drive(0, 32'h48, 0, 0, 0);
      #1;
      check_model("post0");
      m_step(0, 32'h48, 0, 0, 0);
      @(negedge clock);
      #1;
      check_model("post1");
      m_step(0, 32'h48, 0, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         bit          lv, rv, rt, fl;
         logic [31:0] pc;
         lv = ($urandom % 4) != 0;
         pc = $urandom;
         rv = ($urandom % 2) != 0;
         rt = ($urandom % 2) != 0;
         fl = ($urandom % 20) == 0;
         @(negedge clock);
         drive(lv, pc, rv, rt, fl);
         #1;
         check_model($sformatf("rnd%0d", n));
         m_step(lv, pc, rv, rt, fl);
      end

      @(negedge clock);
      drive(0, 32'h0, 0, 0, 0);
      #1;
      check_model("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/z_branch_pred_ctrl.md
Z_BRANCH_PRED_CTRL -- requirements
Module: z_branch_pred_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning log2 of predictor table entries (16).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the maximum number of unresolved branches in flight.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port lookup_valid  input  1  meaning a fetched branch requests a prediction this cycle.
REQ-006 SHALL have port lookup_pc  input  32  meaning the byte PC of that branch.
REQ-007 SHALL have port lookup_ready  output  1  meaning a lookup is accepted this cycle; equals NOT full.
REQ-008 SHALL have port predict_taken  output  1  meaning the combinational prediction for lookup_pc.
REQ-009 SHALL have port resolve_valid  input  1  meaning the oldest in-flight branch has resolved.
REQ-010 SHALL have port resolve_taken  input  1  meaning the actual outcome of that branch.
REQ-011 SHALL have port flush  input  1  meaning discard all in-flight entries.
REQ-012 SHALL have port mispredict  output  1  meaning a registered one-cycle pulse: the resolved outcome differed from the stored prediction.
REQ-013 SHALL have port resolve_err  output  1  meaning a registered one-cycle pulse: resolve_valid arrived while empty.
REQ-014 SHALL have port inflight_count  output  $clog2(DEPTH+1)  meaning the current in-flight occupancy.

Function
REQ-015 SHALL hold 2**IDX_W 2-bit saturating counters; the prediction is the counter MSB.
REQ-016 SHALL increment the counter on taken, saturating at 11, and decrement it on not-taken, saturating at 00.
REQ-017 SHALL compute the index as lookup_pc[IDX_W+1:2] (word-aligned).
REQ-018 SHALL, on an accepted lookup (lookup_valid AND lookup_ready), push {index, predict_taken} into an in-flight FIFO in the same cycle.
REQ-019 SHALL, on resolve_valid with a non-empty FIFO, pop the head, update that stored index's counter with resolve_taken, and assert mispredict on the next cycle if resolve_taken != stored prediction.
REQ-020 SHALL ignore resolve_valid with an empty FIFO (no counter change) and pulse resolve_err on the next cycle.
REQ-021 SHALL drive predict_taken from the pre-update counter value when a lookup and an update target the same index in one cycle; the update is visible from the next cycle.
REQ-022 SHALL support simultaneous push and pop; occupancy is unchanged; lookup_ready is based on occupancy at cycle start only.
REQ-023 SHALL, on flush, empty the FIFO at the clock edge while keeping the counters.
REQ-024 SHALL, when flush coincides with resolve, apply the resolve's counter update and mispredict; a coincident lookup is not pushed.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH; a push when full is impossible because lookup_ready is low.

Reset
REQ-026 SHALL, on reset, set all counters to 01 (weakly not-taken), empty the FIFO, and clear mispredict=0, resolve_err=0, inflight_count=0; hence lookup_ready=1 and predict_taken=0.
REQ-027 SHALL abort any in-flight tracking when reset is asserted mid-operation; no pulse is emitted after reset deasserts.

Configuration
REQ-028 SHALL, with BP_GSHARE_EN defined, keep an IDX_W-bit global history register (reset 0) that shifts in resolve_taken on each valid pop; index = lookup_pc[IDX_W+1:2] XOR history; updates use the FIFO-stored index.
REQ-029 SHALL, without BP_GSHARE_EN, contain no history register and use the plain PC index.

Structure
REQ-030 SHALL place counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the reset counter value in shared package z_bp_pkg.
REQ-031 SHALL implement the saturating next-state as sub-module z_sat_counter2 (inputs: count, taken; output: next count).

Verification
REQ-032 SHALL verify: after reset, lookup pc=0x40 -> predict_taken=0; resolve taken twice, lookup 0x40 -> predict_taken=1, with mispredict pulsing on the first resolve only.
REQ-033 SHALL verify: 4 lookups without resolve -> inflight_count=4, lookup_ready=0; one resolve -> ready=1 next cycle.
REQ-034 SHALL verify: resolve with empty FIFO -> resolve_err=1 for one cycle; counters unchanged.
REQ-035 SHALL verify: 3 in flight, flush+resolve(taken) same cycle -> count=0, head counter incremented, mispredict per stored prediction.
REQ-036 SHALL verify: lookup 0x40 and resolve for index 0 (from pc 0x00, 0x40 aliases) same cycle -> old prediction returned, new value next cycle.
REQ-037 SHALL verify, with BP_GSHARE_EN: history 0b0001, lookup 0x04 -> index 0 used and updated.
